sm83_irq_ctrl: RTL and testbench
================================

SM83_IRQ_CTRL -- requirements
Module: sm83_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 5: number of interrupt source lines, legal range 1..8.
REQ-002 SHALL have parameter IF_ADR, default 16'hFF0F: address of the interrupt flag register (IF).
REQ-003 SHALL have parameter IE_ADR, default 16'hFFFF: address of the interrupt enable register (IE).
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port adr, input, 16: CPU address bus.
REQ-007 SHALL have port din, input, 8: CPU write data.
REQ-008 SHALL have port dout, output, 8: register read data.
REQ-009 SHALL have port dout_oe, output, 1: high when dout drives the CPU data bus.
REQ-010 SHALL have port p_rd, input, 1: CPU read strobe, active-high.
REQ-011 SHALL have port p_wr, input, 1: CPU write strobe, active-high.
REQ-012 SHALL have port irq_src, input, NUM_SRC: peripheral request lines, rising-edge significant.
REQ-013 SHALL have port irq, output, 8: pending-and-enabled requests to the CPU.
REQ-014 SHALL have port iack, input, 8: CPU acknowledge, at most one bit high.

Function
REQ-015 SHALL hold IF[NUM_SRC-1:0], IE[7:0], a registered copy of irq_src and a registered copy of p_wr.
REQ-016 SHALL set IF[i] on each clock where irq_src[i] is 1 and its registered copy is 0; a held-high source sets IF once only.
REQ-017 SHALL perform a register write on the first clock where p_wr is 1 and the registered p_wr is 0, with adr sampled on that clock; a held p_wr SHALL NOT repeat the write.
REQ-018 A write to IF_ADR SHALL load IF from din[NUM_SRC-1:0]; a write to IE_ADR SHALL load all 8 IE bits from din.
REQ-019 SHALL clear IF[i] on each clock where iack[i] is 1; iack bits at or above NUM_SRC SHALL be ignored.
REQ-020 Same-bit, same-clock priority SHALL be: source edge set > iack clear > bus write; a new edge is never lost.
REQ-021 irq[i] SHALL be IF[i] & IE[i] for i < NUM_SRC, and 0 otherwise, combinational from the registers.
REQ-022 Latency: an irq_src edge on clock n SHALL make irq valid after clock n (visible in cycle n+1); an iack on clock n SHALL drop irq after clock n.
REQ-023 dout_oe SHALL be p_rd & (adr==IF_ADR | adr==IE_ADR), combinational.
REQ-024 IF reads SHALL return IF in bits NUM_SRC-1:0 and 1 in all upper bits.
REQ-025 IE reads SHALL return all 8 IE bits.
REQ-026 dout SHALL be 8'hFF when dout_oe is 0.
REQ-027 If IF_ADR equals IE_ADR, the IF function SHALL take precedence for reads and writes.
REQ-028 A read in the same clock as an update SHALL return the pre-update register value.
REQ-029 Simultaneous edges on several sources SHALL all be captured; prioritisation among requests is the CPU's function, not this block's.

Reset
REQ-030 While reset is low, IF and IE SHALL be 0, the registered irq_src SHALL be all ones, and the registered p_wr SHALL be 1.
REQ-031 While reset is low, irq SHALL be 0, with no clock required.
REQ-032 As a consequence of REQ-030, sources already high at reset release, and a p_wr held across reset release, SHALL NOT cause a spurious set or write.
REQ-033 Reset asserted mid-write or mid-acknowledge SHALL abort the operation, with no partial update.

Verification
REQ-034 Edge capture: write IE=8'h1F; pulse irq_src[2] for 1 clock -> irq=8'h04 next cycle; read IF -> 8'hE4.
REQ-035 Held source: hold irq_src[0] high for 10 clocks; iack=8'h01 at clock 3 -> irq[0] clears and stays 0 to clock 10.
REQ-036 Collision: irq_src[1] rises on the same clock as iack=8'h02 -> IF[1] remains 1.
REQ-037 Collision: irq_src[3] rises on the same clock as a write IF=8'h00 -> IF=8'h08.
REQ-038 Bus: held p_wr writing IE=8'hA5 for 4 clocks -> exactly one update.
REQ-038 (cont.) Read IE -> 8'hA5 with dout_oe=1; read adr 16'hFF10 -> dout_oe=0, dout=8'hFF.
REQ-039 Reset: with IF=8'h1F and IE=8'hFF, assert reset asynchronously mid-cycle -> irq=0 immediately.
REQ-039 (cont.) After release with all irq_src high -> IF stays 8'h00.

Source files
------------

// File: rtl/sm83_irq_ctrl.sv
// sm83_irq_ctrl: SM83-style interrupt controller with an IF flag register and an IE enable register.
// Peripheral request lines set IF on rising edges. The CPU acknowledge clears IF bits.
// Both registers are CPU-accessible on a simple strobe bus.
//
// Bus semantics: p_wr and p_rd are level strobes. A write is committed once, on
// the first clock where p_wr is high after being low, using adr/din from that
// clock. Holding p_wr high never repeats the write. Reads are purely
// combinational. dout_oe marks a decoded read, and dout idles at 8'hFF.
module sm83_irq_ctrl #(
    parameter int          NUM_SRC = 5,
    parameter logic [15:0] IF_ADR  = 16'hFF0F,
    parameter logic [15:0] IE_ADR  = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        adr,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               dout_oe,
    input  logic               p_rd,
    input  logic               p_wr,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [7:0]         irq,
    input  logic [7:0]         iack
);

    logic [NUM_SRC-1:0] if_q;
    logic [NUM_SRC-1:0] if_nxt;
    logic [7:0]         ie_q;
    logic [NUM_SRC-1:0] src_q;
    logic               wr_q;

    logic               sel_if;
    logic               sel_ie;
    logic               wr_pulse;
    logic [7:0]         if_ext;
    logic [7:0]         if_rd;

    // Address decode. IF wins when both addresses are configured equal.
    always_comb begin
        sel_if   = (adr == IF_ADR);
        sel_ie   = (adr == IE_ADR) && !sel_if;
        wr_pulse = p_wr && !wr_q;
    end

    // IF next state. Each later step overrides the earlier ones, so a new source edge beats iack, which beats a bus write.
    always_comb begin
        if_nxt = if_q;
        if (wr_pulse && sel_if) begin
            if_nxt = din[NUM_SRC-1:0];
        end
        if_nxt = if_nxt & ~iack[NUM_SRC-1:0];
        if_nxt = if_nxt | (irq_src & ~src_q);
    end

    // Register update. The edge-detect copies reset high so that lines already high at release are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_q  <= '0;
            ie_q  <= 8'h00;
            src_q <= '1;
            wr_q  <= 1'b1;
        end else begin
            if_q  <= if_nxt;
            src_q <= irq_src;
            wr_q  <= p_wr;
            if (wr_pulse && sel_ie) begin
                ie_q <= din;
            end
        end
    end

    // Request outputs and read mux. Both are combinational from the registers, so reads see pre-update values.
    always_comb begin
        if_ext                = 8'h00;
        if_ext[NUM_SRC-1:0]   = if_q;
        if_rd                 = 8'hFF;
        if_rd[NUM_SRC-1:0]    = if_q;
        irq                   = if_ext & ie_q;
        dout_oe               = p_rd && (sel_if || sel_ie);
        dout                  = 8'hFF;
        if (p_rd && sel_if) begin
            dout = if_rd;
        end else if (p_rd && sel_ie) begin
            dout = ie_q;
        end
    end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// tb_sm83_irq_ctrl: directed checks of edge capture, acknowledge, bus access,
// collision priority and reset behaviour.
module tb_sm83_irq_ctrl;

    localparam int NS = 5;

    logic          clk;
    logic          reset;
    logic [15:0]   adr;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          dout_oe;
    logic          p_rd;
    logic          p_wr;
    logic [NS-1:0] irq_src;
    logic [7:0]    irq;
    logic [7:0]    iack;

    int total;
    int bad;

    sm83_irq_ctrl #(.NUM_SRC(NS), .IF_ADR(16'hFF0F), .IE_ADR(16'hFFFF)) dut (
        .clk     (clk),
        .reset   (reset),
        .adr     (adr),
        .din     (din),
        .dout    (dout),
        .dout_oe (dout_oe),
        .p_rd    (p_rd),
        .p_wr    (p_wr),
        .irq_src (irq_src),
        .irq     (irq),
        .iack    (iack)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Inputs are driven and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        adr  = a;
        din  = d;
        p_wr = 1'b1;
        tick();
        p_wr = 1'b0;
        tick();
    endtask

    task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] exp, input logic exp_oe);
        adr  = a;
        p_rd = 1'b1;
        #1;
        check({tag, "_dout"}, {8'h00, dout}, {8'h00, exp});
        check({tag, "_oe"}, {15'h0, dout_oe}, {15'h0, exp_oe});
        p_rd = 1'b0;
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        adr     = 16'h0000;
        din     = 8'h00;
        p_rd    = 1'b0;
        p_wr    = 1'b0;
        irq_src = '0;
        iack    = 8'h00;

        // Reset state.
        #12;
        check("rst_irq", {8'h00, irq}, 16'h0000);
        check("rst_idle_dout", {8'h00, dout}, 16'h00FF);
        bus_read("rst_if", 16'hFF0F, 8'hE0, 1'b1);
        bus_read("rst_ie", 16'hFFFF, 8'h00, 1'b1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick();

        // Edge capture.
        bus_write(16'hFFFF, 8'h1F);
        bus_read("ie_1f", 16'hFFFF, 8'h1F, 1'b1);
        irq_src = 5'b00100;
        bus_read("if_pre_update", 16'hFF0F, 8'hE0, 1'b1);
        tick();
        check("edge_irq", {8'h00, irq}, 16'h0004);
        irq_src = '0;
        tick();
        bus_read("edge_if", 16'hFF0F, 8'hE4, 1'b1);
        iack = 8'h04;
        tick();
        iack = 8'h00;
        check("ack_irq", {8'h00, irq}, 16'h0000);

        // Held source.
        irq_src = 5'b00001;
        tick();
        check("held_c1", {8'h00, irq}, 16'h0001);
        tick();
        iack = 8'h01;
        tick();
        iack = 8'h00;
        check("held_c3", {8'h00, irq}, 16'h0000);
        for (int i = 4; i <= 10; i++) begin
            tick();
            check($sformatf("held_c%0d", i), {8'h00, irq}, 16'h0000);
        end
        irq_src = '0;
        tick();

        // Edge beats iack.
        irq_src = 5'b00010;
        iack    = 8'h02;
        tick();
        iack = 8'h00;
        check("edge_vs_ack", {8'h00, irq}, 16'h0002);
        irq_src = '0;
        iack    = 8'h02;
        tick();
        iack = 8'h00;
        check("ack_clear", {8'h00, irq}, 16'h0000);

        // Edge beats a bus write.
        bus_write(16'hFF0F, 8'h11);
        bus_read("if_11", 16'hFF0F, 8'hF1, 1'b1);
        adr     = 16'hFF0F;
        din     = 8'h00;
        p_wr    = 1'b1;
        irq_src = 5'b01000;
        tick();
        p_wr    = 1'b0;
        irq_src = '0;
        tick();
        bus_read("edge_vs_wr", 16'hFF0F, 8'hE8, 1'b1);
        check("edge_vs_wr_irq", {8'h00, irq}, 16'h0008);

        // IF write truncation, and iack above NUM_SRC is ignored.
        bus_write(16'hFF0F, 8'hFF);
        bus_read("if_ff", 16'hFF0F, 8'hFF, 1'b1);
        check("irq_all", {8'h00, irq}, 16'h001F);
        iack = 8'hE0;
        tick();
        iack = 8'h00;
        bus_read("iack_high", 16'hFF0F, 8'hFF, 1'b1);
        bus_write(16'hFF0F, 8'h00);

        // A held write commits only once.
        adr  = 16'hFFFF;
        din  = 8'hA5;
        p_wr = 1'b1;
        tick();
        din = 8'h5A;
        for (int i = 0; i < 3; i++) tick();
        p_wr = 1'b0;
        tick();
        bus_read("ie_a5", 16'hFFFF, 8'hA5, 1'b1);
        bus_read("other_adr", 16'hFF10, 8'hFF, 1'b0);
        adr = 16'hFF0F;
        #1;
        check("no_rd_oe", {15'h0, dout_oe}, 16'h0000);
        check("no_rd_dout", {8'h00, dout}, 16'h00FF);

        // Asynchronous reset mid-cycle.
        bus_write(16'hFFFF, 8'hFF);
        bus_write(16'hFF0F, 8'h1F);
        check("pre_rst_irq", {8'h00, irq}, 16'h001F);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_irq", {8'h00, irq}, 16'h0000);
        bus_read("rst2_ie", 16'hFFFF, 8'h00, 1'b1);
        irq_src = 5'b11111;
        adr     = 16'hFF0F;
        din     = 8'hFF;
        p_wr    = 1'b1;
        tick();
        #3;
        reset = 1'b1;
        tick();
        tick();
        bus_read("post_rst_if", 16'hFF0F, 8'hE0, 1'b1);
        p_wr = 1'b0;
        tick();
        bus_read("post_rst_if2", 16'hFF0F, 8'hE0, 1'b1);

        // A fresh edge after release is still captured.
        irq_src = 5'b00000;
        tick();
        irq_src = 5'b10000;
        tick();
        bus_read("post_rst_edge", 16'hFF0F, 8'hF0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
